muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, in the EX stage beside the main ALU.
- Consumes the 4-bit ALU control code and the EX operands; executes mult/div iteratively and serves mfhi/mflo.
- Raises a stall request to the hazard logic while an operation is in flight and EX presents a HI/LO-dependent op.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH each.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX holds a valid, non-flushed instruction.
- alu_contr  in  4  ALU control code: 1000 mult, 1001 div, 0011 mfhi, 0100 mflo; all other codes are ignored.
- src_a  in  WIDTH  rs operand (multiplicand / dividend).
- src_b  in  WIDTH  rt operand (multiplier / divisor).
- hilo_out  out  WIDTH  combinational: HI when code is 0011, LO when code is 0100, else 0.
- hi  out  WIDTH  current HI register.
- lo  out  WIDTH  current LO register.
- busy  out  1  operation in flight.
- stall  out  1  freeze IF/ID/EX.
- done  out  1  one-cycle pulse when HI/LO are updated.
- div_zero  out  1  one-cycle pulse with done when the finished div had divisor 0.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - state=IDLE.
  - hi=0, lo=0, busy=0, done=0, div_zero=0.
  - counter and internal datapath registers cleared.
  - An in-flight operation is abandoned; HI/LO are not written.
- Operand semantics:
  - All operands are signed two's complement.
  - Operands are latched at accept as absolute values, plus sign flags: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- State machine IDLE -> RUN -> FIN -> IDLE.
- IDLE:
  - Accept on a clock edge when ex_valid=1 and alu_contr is 1000 or 1001.
  - Latch |src_a|, |src_b|, signs, and op; counter=0; go to RUN.
- RUN, 32 cycles, counter 0..31:
  - mult: shift-add. If the multiplier LSB is 1, add the multiplicand into the upper accumulator; shift the 64-bit {acc,mplr} right by 1, keeping the carry.
  - div: restoring division. Shift {rem,quo} left by 1; trial-subtract the divisor from rem; if non-negative, keep the result and set quo LSB=1.
  - Go to FIN on the edge where counter=31.
- FIN, 1 cycle:
  - Apply sign correction.
  - mult: {hi,lo} = 64-bit signed product.
  - div: lo = quotient truncated toward zero; hi = remainder.
  - Divisor 0: hi=src_a as latched (original signed value), lo=all ones, div_zero=1. Same latency as a normal div.
  - 0x80000000 / -1: lo=0x80000000, hi=0 (falls out of the unsigned datapath; no special case).
  - done=1 for the cycle after the FIN edge; state=IDLE.
- Timing:
  - Accept at edge E0; busy=1 from E0 to E33; HI/LO are valid after E33.
  - Total latency is 33 cycles from accept to HI/LO update.
- Stall:
  - stall = busy & ex_valid & alu_contr in {1000, 1001, 0011, 0100}.
  - It is combinational; other ALU codes never stall.
  - The accept cycle itself does not stall, because busy=0 there.
- Mid-operation flush: ex_valid dropping does not abort an accepted operation; it completes and writes HI/LO.
- Start while busy: ignored. It is prevented by stall, and the bench flags it if it occurs.
- mfhi/mflo while IDLE: hilo_out reflects the committed HI/LO with zero latency.

Test Plan:
- mult 7 x -3 (src_a=0x00000007, src_b=0xFFFFFFFD) -> busy high 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once.
- div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- div 5 / 0 -> after 33 cycles, hi=0x00000005, lo=0xFFFFFFFF; div_zero and done both pulse.
- Issue mult 0x0000FFFF x 0x0000FFFF, then present mfhi next cycle -> stall=1 for all busy cycles; after release hilo_out=0x00000000 and lo=0xFFFE0001. An add code (0010) during busy -> stall=0.
- Deassert rst_n at RUN counter=10 after hi/lo were preloaded by a prior op -> hi=lo=0 immediately and busy=0; the next mult 3 x 4 gives lo=12, hi=0.
- mult 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0. Drop ex_valid during RUN -> the op still completes with the same values.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// EX-stage bus between the pipeline and the multiply/divide unit.
// master = pipeline/hazard side, slave = muldiv_unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             ex_valid;
  logic [3:0]       alu_contr;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] hilo_out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_zero;

  modport master (
    output ex_valid, alu_contr, src_a, src_b,
    input  hilo_out, hi, lo, busy, stall, done, div_zero
  );

  modport slave (
    input  ex_valid, alu_contr, src_a, src_b,
    output hilo_out, hi, lo, busy, stall, done, div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fixed in a final cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b0011;
  localparam logic [3:0] OP_MFLO = 4'b0100;
  localparam int unsigned PW     = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e state_q, state_d;

  logic             accept_c, step_c, fin_c, start_c, last_c;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, mq_q, opd_q, orig_a_q;
  logic             is_div_q, neg_res_q, neg_rem_q, bzero_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, dz_q;

  function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  assign start_c = bus.ex_valid &
                   ((bus.alu_contr == OP_MULT) || (bus.alu_contr == OP_DIV));
  assign last_c  = (cnt_q == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_c) state_d = S_RUN;
      S_RUN:   if (last_c)  state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM control strobes
  always_comb begin
    accept_c = 1'b0;
    step_c   = 1'b0;
    fin_c    = 1'b0;
    case (state_q)
      S_IDLE:  accept_c = start_c;
      S_RUN:   step_c   = 1'b1;
      S_FIN:   fin_c    = 1'b1;
      default: ;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide
  logic [WIDTH:0]   add_sum_c, rem_sh_c, trial_c;
  logic [WIDTH-1:0] acc_step_c, mq_step_c;

  always_comb begin
    add_sum_c = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opd_q} : '0);
    rem_sh_c  = {acc_q, mq_q[WIDTH-1]};
    trial_c   = rem_sh_c - {1'b0, opd_q};
    if (!is_div_q) begin
      acc_step_c = add_sum_c[WIDTH:1];
      mq_step_c  = {add_sum_c[0], mq_q[WIDTH-1:1]};
    end else if (!trial_c[WIDTH]) begin
      acc_step_c = trial_c[WIDTH-1:0];
      mq_step_c  = {mq_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step_c = rem_sh_c[WIDTH-1:0];
      mq_step_c  = {mq_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction of the magnitude results
  logic [PW-1:0]    prod_c;
  logic [WIDTH-1:0] hi_fin_c, lo_fin_c;

  always_comb begin
    prod_c = neg_res_q ? -{acc_q, mq_q} : {acc_q, mq_q};
    if (!is_div_q) begin
      hi_fin_c = prod_c[PW-1:WIDTH];
      lo_fin_c = prod_c[WIDTH-1:0];
    end else if (bzero_q) begin
      hi_fin_c = orig_a_q;
      lo_fin_c = '1;
    end else begin
      hi_fin_c = neg_rem_q ? -acc_q : acc_q;
      lo_fin_c = neg_res_q ? -mq_q : mq_q;
    end
  end

  // Datapath and operand latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      opd_q     <= '0;
      orig_a_q  <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
    end else if (accept_c) begin
      is_div_q  <= (bus.alu_contr == OP_DIV);
      cnt_q     <= '0;
      acc_q     <= '0;
      orig_a_q  <= bus.src_a;
      neg_res_q <= bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1];
      neg_rem_q <= bus.src_a[WIDTH-1];
      bzero_q   <= (bus.src_b == '0);
      // Multiplier/dividend sit in the low half; the other operand stays put
      if (bus.alu_contr == OP_DIV) begin
        mq_q  <= abs_f(bus.src_a);
        opd_q <= abs_f(bus.src_b);
      end else begin
        mq_q  <= abs_f(bus.src_b);
        opd_q <= abs_f(bus.src_a);
      end
    end else if (step_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
      acc_q <= acc_step_c;
      mq_q  <= mq_step_c;
    end
  end

  // Architectural HI/LO and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= fin_c;
      dz_q   <= fin_c & is_div_q & bzero_q;
      if (accept_c)   busy_q <= 1'b1;
      else if (fin_c) busy_q <= 1'b0;
      if (fin_c) begin
        hi_q <= hi_fin_c;
        lo_q <= lo_fin_c;
      end
    end
  end

  // mfhi/mflo read port and hazard request
  always_comb begin
    bus.hilo_out = '0;
    case (bus.alu_contr)
      OP_MFHI: bus.hilo_out = hi_q;
      OP_MFLO: bus.hilo_out = lo_q;
      default: ;
    endcase
  end

  assign bus.stall = busy_q & bus.ex_valid &
                     ((bus.alu_contr == OP_MULT) || (bus.alu_contr == OP_DIV) ||
                      (bus.alu_contr == OP_MFHI) || (bus.alu_contr == OP_MFLO));

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;

endmodule
